// File: rtl/window_pkg.sv
// Shared types and geometry helpers for the window scan / position pairing path.
package window_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } scan_state_t;

    // $clog2 of 1 is 0, so coordinates are never narrower than one bit.
    function automatic int coord_width(input int extent);
        return (extent < 2) ? 1 : $clog2(extent);
    endfunction

    function automatic int last_pos(input int img, input int win, input int step);
        return ((img - win) / step) * step;
    endfunction

endpackage

// File: rtl/window_scan_axis_step_counter.sv
// One raster axis: counts 0, STEP, 2*STEP ... up to the last value not exceeding MAX,
// then wraps to zero on the next advance.
module axis_step_counter #(
    parameter int W    = 6,
    parameter int MAX  = 21,
    parameter int STEP = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic         i_adv,
    output logic [W-1:0] o_val,
    output logic         o_wrap
);

    localparam logic [W:0] MAX_W    = (W+1)'(MAX);
    localparam logic [W:0] STEP_W   = (W+1)'(STEP);
    localparam bit         STEP_BIG = (STEP > MAX);

    logic [W-1:0] r_val;
    logic [W:0]   w_next;

    // One extra bit so val+STEP cannot wrap before the compare.
    assign w_next = {1'b0, r_val} + STEP_W;
    assign o_wrap = STEP_BIG || (w_next > MAX_W);
    assign o_val  = r_val;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_val <= '0;
        end else if (i_load) begin
            r_val <= '0;
        end else if (i_adv) begin
            r_val <= o_wrap ? '0 : w_next[W-1:0];
        end
    end

endmodule

// File: rtl/window_scan.sv
// Raster generator of classifier window origins on a valid/ready stream.
// Define WINDOW_SCAN_LAST_EN to add the window_pos_last end-of-frame marker.
module window_scan
    import window_pkg::*;
#(
    parameter int IMG_WIDTH  = 45,
    parameter int IMG_HEIGHT = 45,
    parameter int WIN_WIDTH  = 24,
    parameter int WIN_HEIGHT = 24,
    parameter int STEP_X     = 1,
    parameter int STEP_Y     = 1,
    localparam int W_X       = coord_width(IMG_WIDTH),
    localparam int W_Y       = coord_width(IMG_HEIGHT)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    output logic           busy,
    output logic           done,
    output logic           window_pos_valid,
    input  logic           window_pos_ready,
    output logic [W_X-1:0] window_pos_x,
`ifdef WINDOW_SCAN_LAST_EN
    output logic           window_pos_last,
`endif
    output logic [W_Y-1:0] window_pos_y
);

    // state | meaning
    // IDLE  | waiting for start, coordinates parked at (0,0)
    // SCAN  | presenting (x,y); advances on each handshake
    // DONE  | single-cycle done pulse, then back to IDLE

    localparam int MAX_X = IMG_WIDTH - WIN_WIDTH;
    localparam int MAX_Y = IMG_HEIGHT - WIN_HEIGHT;

    scan_state_t r_state;
    scan_state_t w_next_state;
    logic        w_hs;
    logic        w_load;
    logic        w_x_wrap;
    logic        w_y_wrap;

    assign w_hs   = (r_state == SCAN) && window_pos_ready;
    assign w_load = (r_state != SCAN);

    // y only moves when x rolls over; on the final beat both roll back to zero.
    axis_step_counter #(.W(W_X), .MAX(MAX_X), .STEP(STEP_X)) u_x_cnt (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_load),
        .i_adv  (w_hs),
        .o_val  (window_pos_x),
        .o_wrap (w_x_wrap)
    );

    axis_step_counter #(.W(W_Y), .MAX(MAX_Y), .STEP(STEP_Y)) u_y_cnt (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_load),
        .i_adv  (w_hs && w_x_wrap),
        .o_val  (window_pos_y),
        .o_wrap (w_y_wrap)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            IDLE:    if (start) w_next_state = SCAN;
            SCAN:    if (w_hs && w_x_wrap && w_y_wrap) w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Outputs decode the state register only, so reset clears them asynchronously.
    always_comb begin
        window_pos_valid = (r_state == SCAN);
        busy             = (r_state == SCAN);
        done             = (r_state == DONE);
    end

`ifdef WINDOW_SCAN_LAST_EN
    localparam int LAST_X = last_pos(IMG_WIDTH, WIN_WIDTH, STEP_X);
    localparam int LAST_Y = last_pos(IMG_HEIGHT, WIN_HEIGHT, STEP_Y);

    assign window_pos_last = window_pos_valid
                             && (window_pos_x == W_X'(LAST_X))
                             && (window_pos_y == W_Y'(LAST_Y));
`endif

endmodule
